grf_wb_port: RTL and testbench

//  General register file with its writeback port. Sits at the W/D boundary of the 5-stage MIPS pipeline.

---
 rtl/mips_defs.sv | 12 +
 rtl/wb_data_sel.sv | 26 ++
 rtl/grf_wb_port.sv | 80 ++++++++
 tb/tb_grf_wb_port.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_defs.sv
// Constants shared by the MIPS stage control units and the writeback path:
// the reg_data_op encodings and the special register numbers.
package mips_defs;

    localparam logic [2:0] RDO_ALU  = 3'd0;
    localparam logic [2:0] RDO_DM   = 3'd1;
    localparam logic [2:0] RDO_PC8  = 3'd2;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_RA   = 5'd31;

endpackage

// File: rtl/wb_data_sel.sv
// Writeback data mux: picks ALU result, load data or the link address (pc+8).
// Kept standalone so the forwarding unit can reuse the same selection.
module wb_data_sel
    import mips_defs::*;
#(
    parameter int DW = 32
) (
    input  logic [2:0]    reg_data_op,
    input  logic [DW-1:0] alu_out_W,
    input  logic [DW-1:0] dm_out_W,
    input  logic [DW-1:0] pc_W,
    output logic [DW-1:0] wb_data
);

    // Unused encodings deliberately yield zero rather than a stale source.
    always_comb begin
        wb_data = '0;
        case (reg_data_op)
            RDO_ALU: wb_data = alu_out_W;
            RDO_DM:  wb_data = dm_out_W;
            RDO_PC8: wb_data = pc_W + DW'(8);
            default: wb_data = '0;
        endcase
    end

endmodule

// File: rtl/grf_wb_port.sv
// General register file with W-stage writeback port and write-through bypass to D.
// Optional build macro GRF_TRACE_EN prints one line per committed write.
module grf_wb_port
    import mips_defs::*;
#(
    parameter int NREG = 32,
    parameter int DW   = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          reg_write,
    input  logic [4:0]    reg_addr,
    input  logic [2:0]    reg_data_op,
    input  logic [DW-1:0] alu_out_W,
    input  logic [DW-1:0] dm_out_W,
    input  logic [DW-1:0] pc_W,
    input  logic [4:0]    rs_addr,
    input  logic [4:0]    rt_addr,
    output logic [DW-1:0] rs_data,
    output logic [DW-1:0] rt_data,
    output logic [DW-1:0] wb_data,
    output logic [31:0]   wb_count
);

    logic [DW-1:0] regs [NREG];
    logic          we_eff;

    wb_data_sel #(.DW(DW)) u_sel (
        .reg_data_op (reg_data_op),
        .alu_out_W   (alu_out_W),
        .dm_out_W    (dm_out_W),
        .pc_W        (pc_W),
        .wb_data     (wb_data)
    );

    // Writes to $0 and writes during reset neither land nor count.
    assign we_eff = reset & reg_write & (reg_addr != REG_ZERO);

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
            wb_count <= '0;
        end else if (we_eff) begin
            regs[reg_addr] <= wb_data;
            wb_count       <= wb_count + 32'd1;
        end
    end

    // $0 wins over the bypass so a discarded write can never leak through.
    always_comb begin
        rs_data = regs[rs_addr];
        if (rs_addr == REG_ZERO) begin
            rs_data = '0;
        end else if (we_eff && (rs_addr == reg_addr)) begin
            rs_data = wb_data;
        end
    end

    always_comb begin
        rt_data = regs[rt_addr];
        if (rt_addr == REG_ZERO) begin
            rt_data = '0;
        end else if (we_eff && (rt_addr == reg_addr)) begin
            rt_data = wb_data;
        end
    end

`ifdef GRF_TRACE_EN
    always @(posedge clk) begin
        if (we_eff) begin
            $display("%d@%h: $%d <= %h", $time, pc_W, reg_addr, wb_data);
        end
    end
`else
    // Trace build disabled: no simulation output from the register file.
`endif

endmodule

// File: tb/tb_grf_wb_port.sv
// Directed bench for grf_wb_port: a reference register model produces expected
// values that are queued at drive time and popped when the DUT output is sampled.
module tb_grf_wb_port;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        reg_write;
    logic [4:0]  reg_addr;
    logic [2:0]  reg_data_op;
    logic [31:0] alu_out_W;
    logic [31:0] dm_out_W;
    logic [31:0] pc_W;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] wb_data;
    logic [31:0] wb_count;

    exp_t        scoreQ[$];
    logic [31:0] modelRegs [32];
    logic [31:0] modelCount;
    int          nCompared   = 0;
    int          nMismatched = 0;

    grf_wb_port dut (
        .clk         (clk),
        .reset       (reset),
        .reg_write   (reg_write),
        .reg_addr    (reg_addr),
        .reg_data_op (reg_data_op),
        .alu_out_W   (alu_out_W),
        .dm_out_W    (dm_out_W),
        .pc_W        (pc_W),
        .rs_addr     (rs_addr),
        .rt_addr     (rt_addr),
        .rs_data     (rs_data),
        .rt_data     (rt_data),
        .wb_data     (wb_data),
        .wb_count    (wb_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] modelWb(input logic [2:0] op, input logic [31:0] alu,
                                            input logic [31:0] dm, input logic [31:0] pc);
        case (op)
            3'd0:    return alu;
            3'd1:    return dm;
            3'd2:    return pc + 32'd8;
            default: return 32'h0;
        endcase
    endfunction

    task automatic expectVal(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        scoreQ.push_back(e);
    endtask

    task automatic checkOutput(input logic [31:0] obs);
        exp_t e;
        nCompared++;
        if (scoreQ.size() == 0) begin
            nMismatched++;
            $display("[TB] FAIL scoreboard_empty: observed=%h expected=<none>", obs);
        end else begin
            e = scoreQ.pop_front();
            assert (obs === e.val) else begin
                nMismatched++;
                $error("[TB] FAIL %s: observed=%h expected=%h", e.tag, obs, e.val);
            end
        end
    endtask

    // One W-stage cycle: checks the pre-edge bypass view, then the post-edge count.
    task automatic applyStimulus(input string tag, input logic we, input logic [4:0] addr,
                                 input logic [2:0] op, input logic [31:0] alu,
                                 input logic [31:0] dm, input logic [31:0] pc,
                                 input logic [4:0] rsA, input logic [4:0] rtA);
        logic [31:0] expWb;
        logic        eff;
        @(negedge clk);
        reg_write   = we;
        reg_addr    = addr;
        reg_data_op = op;
        alu_out_W   = alu;
        dm_out_W    = dm;
        pc_W        = pc;
        rs_addr     = rsA;
        rt_addr     = rtA;
        #1;
        expWb = modelWb(op, alu, dm, pc);
        eff   = reset && we && (addr != 5'd0);
        expectVal({tag, "_wb"}, expWb);
        checkOutput(wb_data);
        expectVal({tag, "_rs_pre"}, (rsA == 5'd0) ? 32'h0 :
                  (eff && rsA == addr) ? expWb : modelRegs[rsA]);
        checkOutput(rs_data);
        expectVal({tag, "_rt_pre"}, (rtA == 5'd0) ? 32'h0 :
                  (eff && rtA == addr) ? expWb : modelRegs[rtA]);
        checkOutput(rt_data);
        @(posedge clk);
        if (!reset) begin
            for (int i = 0; i < 32; i++) modelRegs[i] = 32'h0;
            modelCount = 32'h0;
        end else if (eff) begin
            modelRegs[addr] = expWb;
            modelCount      = modelCount + 32'd1;
        end
        #1;
        expectVal({tag, "_count"}, modelCount);
        checkOutput(wb_count);
    endtask

    task automatic readBack(input string tag, input logic [4:0] a, input logic [4:0] b);
        @(negedge clk);
        reg_write = 1'b0;
        rs_addr   = a;
        rt_addr   = b;
        #1;
        expectVal({tag, "_rs"}, modelRegs[a]);
        checkOutput(rs_data);
        expectVal({tag, "_rt"}, modelRegs[b]);
        checkOutput(rt_data);
    endtask

    initial begin
        reset       = 1'b0;
        reg_write   = 1'b0;
        reg_addr    = 5'd0;
        reg_data_op = 3'd0;
        alu_out_W   = 32'h0;
        dm_out_W    = 32'h0;
        pc_W        = 32'h0;
        rs_addr     = 5'd0;
        rt_addr     = 5'd0;
        for (int i = 0; i < 32; i++) modelRegs[i] = 32'h0;
        modelCount = 32'h0;

        // Reset for two edges, then every address reads zero.
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 32; i++) begin
            readBack("t1_reset_read", 5'(i), 5'(31 - i));
        end
        #1;
        expectVal("t1_count", 32'h0);
        checkOutput(wb_count);

        // Bypass then commit of $5, read on both ports.
        applyStimulus("t2_write5", 1'b1, 5'd5, 3'd0, 32'h1234, 32'h0, 32'h0, 5'd5, 5'd5);
        readBack("t2_read5", 5'd5, 5'd5);
        expectVal("t2_const", 32'h1234);
        checkOutput(rs_data);

        // Writes to $0 are discarded and uncounted.
        applyStimulus("t3_zero", 1'b1, 5'd0, 3'd0, 32'hFFFF, 32'h0, 32'h0, 5'd0, 5'd0);
        readBack("t3_read0", 5'd0, 5'd0);

        // Data-select encodings.
        applyStimulus("t4_pc8", 1'b1, 5'd31, 3'd2, 32'h0, 32'h0, 32'h0000_3000, 5'd31, 5'd0);
        readBack("t4_read31", 5'd31, 5'd31);
        expectVal("t4_pc8_const", 32'h0000_3008);
        checkOutput(rs_data);
        applyStimulus("t4_dm", 1'b1, 5'd8, 3'd1, 32'h1111, 32'hDEAD_BEEF, 32'h0, 5'd8, 5'd31);
        readBack("t4_read8", 5'd8, 5'd8);
        expectVal("t4_dm_const", 32'hDEAD_BEEF);
        checkOutput(rt_data);
        applyStimulus("t4_op5", 1'b1, 5'd9, 3'd5, 32'hAAAA, 32'hBBBB, 32'hCCCC, 5'd9, 5'd8);
        applyStimulus("t4_pcwrap", 1'b1, 5'd10, 3'd2, 32'h0, 32'h0, 32'hFFFF_FFFC, 5'd10, 5'd9);
        applyStimulus("t4_idle", 1'b0, 5'd11, 3'd0, 32'h5555, 32'h0, 32'h0, 5'd11, 5'd10);

        // Fill the whole file, then a mid-stream reset with a pending write.
        for (int i = 1; i < 32; i++) begin
            applyStimulus("t5_fill", 1'b1, 5'(i), 3'd0, 32'h0101_0101 * i, 32'h0, 32'h0,
                          5'(i), 5'(i - 1));
        end
        reset = 1'b0;
        applyStimulus("t5_reset", 1'b1, 5'd7, 3'd0, 32'h7777, 32'h0, 32'h0, 5'd7, 5'd3);
        for (int i = 0; i < 32; i++) begin
            readBack("t5_cleared", 5'(i), 5'(i));
        end
        reset = 1'b1;
        applyStimulus("t5_first", 1'b1, 5'd7, 3'd0, 32'h7777, 32'h0, 32'h0, 5'd7, 5'd7);
        readBack("t5_read7", 5'd7, 5'd3);

        // Counter wrap from all-ones.
        @(negedge clk);
        force dut.wb_count = 32'hFFFF_FFFF;
        #1;
        release dut.wb_count;
        modelCount = 32'hFFFF_FFFF;
        #1;
        expectVal("t6_preload", 32'hFFFF_FFFF);
        checkOutput(wb_count);
        applyStimulus("t6_zero", 1'b1, 5'd0, 3'd1, 32'h0, 32'h1, 32'h0, 5'd0, 5'd3);
        applyStimulus("t6_wrap", 1'b1, 5'd3, 3'd0, 32'h3333, 32'h0, 32'h0, 5'd3, 5'd3);
        expectVal("t6_wrap_const", 32'h0);
        checkOutput(wb_count);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
